// File: rtl/dsp_result_capture.sv
// Result-side companion to a DSP48A1 slice: tracks issued operations through the
// slice latency with a valid/tag token pipe and captures each P/CARRYOUT into a credit-managed FIFO.
module dsp_result_capture #(
  parameter int A0REG      = 0,
  parameter int A1REG      = 1,
  parameter int B0REG      = 0,
  parameter int B1REG      = 1,
  parameter int MREG       = 1,
  parameter int PREG       = 1,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [47:0]      p_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_p,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       inflight,
  output logic             ovf_err
);

  localparam int A_LAT = A0REG + A1REG;
  localparam int B_LAT = B0REG + B1REG;
  localparam int LAT   = ((A_LAT > B_LAT) ? A_LAT : B_LAT) + MREG + PREG;
  localparam int STG   = (LAT == 0) ? 1 : LAT;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 4;
  localparam int ENT_W = 48 + 1 + TAG_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [STG-1:0]   tok_vld_q, tok_vld_d;
  logic [TAG_W-1:0] tok_tag_q [STG];
  logic [TAG_W-1:0] tok_tag_d [STG];
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic [3:0]       inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             ovf_q, ovf_d;
  logic             issue_s, push_req_s, push_s, pop_s, full_s;
  logic [TAG_W-1:0] push_tag_s;
  logic [ENT_W-1:0] push_ent_s;
  logic [SUM_W-1:0] credit_sum_s;

  function automatic logic [3:0] count_tokens(input logic [STG-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < STG; k++) begin
      n = n + {3'b000, v[k]};
    end
    return n;
  endfunction

  // Issue and push qualification; flush wins over both
  always_comb begin
    issue_s = in_valid & in_ready_q & ce & ~flush;
    if (LAT == 0) begin
      push_req_s = issue_s;
      push_tag_s = in_tag;
    end else begin
      push_req_s = tok_vld_q[STG-1] & ce & ~flush;
      push_tag_s = tok_tag_q[STG-1];
    end
    push_ent_s = {p_in, carry_in, push_tag_s};
    pop_s      = out_valid_q & out_ready;
    full_s     = (count_q == FULL_CNT);
    push_s     = push_req_s & (~full_s | pop_s);
    ovf_d      = ovf_q | (push_req_s & full_s & ~pop_s);
  end

  // Token pipe next state: advances only with ce, cleared by flush
  always_comb begin
    tok_vld_d = tok_vld_q;
    for (int k = 0; k < STG; k++) begin
      tok_tag_d[k] = tok_tag_q[k];
    end
    if (LAT == 0) begin
      tok_vld_d = {STG{1'b0}};
    end else if (flush) begin
      tok_vld_d = {STG{1'b0}};
    end else if (ce) begin
      tok_vld_d[0] = issue_s;
      tok_tag_d[0] = in_tag;
      for (int k = 1; k < STG; k++) begin
        tok_vld_d[k] = tok_vld_q[k-1];
        tok_tag_d[k] = tok_tag_q[k-1];
      end
    end else begin
      tok_vld_d = tok_vld_q;
    end
    inflight_d = count_tokens(tok_vld_d);
  end

  // FIFO pointer/count next state and the registered head view
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A push into an otherwise-empty FIFO becomes the head directly
    if (count_d == {CNT_W{1'b0}}) begin
      head_d = head_q;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_ent_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    out_valid_d  = (count_d != {CNT_W{1'b0}});
    credit_sum_s = SUM_W'(count_d) + SUM_W'(inflight_d);
    in_ready_d   = (credit_sum_s < SUM_W'(FIFO_DEPTH));
  end

  // Token pipe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_vld_q <= {STG{1'b0}};
      for (int k = 0; k < STG; k++) begin
        tok_tag_q[k] <= {TAG_W{1'b0}};
      end
    end else begin
      tok_vld_q <= tok_vld_d;
      for (int k = 0; k < STG; k++) begin
        tok_tag_q[k] <= tok_tag_d[k];
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= {ENT_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_ent_s;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      head_q      <= {ENT_W{1'b0}};
      inflight_q  <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = head_q[ENT_W-1:TAG_W+1];
  assign out_carry = head_q[TAG_W];
  assign out_tag   = head_q[TAG_W-1:0];
  assign inflight  = inflight_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_dsp_result_capture.sv
// Directed, table-driven bench for dsp_result_capture: default latency-3 instance
// plus a latency-0 instance for the combinational-slice case.
module tb_dsp_result_capture;

  logic        clk, rst, ce, flush, in_valid, carry_in, out_ready;
  logic [3:0]  in_tag;
  logic [47:0] p_in;

  logic        ir, ov, ocy, ovf;
  logic [47:0] op;
  logic [3:0]  otag, inf;
  logic        ir0, ov0, ocy0, ovf0;
  logic [47:0] op0;
  logic [3:0]  otag0, inf0;

  int n_vec = 0;
  int n_err = 0;

  dsp_result_capture u_dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .in_ready(ir),
    .in_tag(in_tag), .p_in(p_in), .carry_in(carry_in), .out_valid(ov), .out_ready(out_ready),
    .out_p(op), .out_carry(ocy), .out_tag(otag), .inflight(inf), .ovf_err(ovf)
  );

  dsp_result_capture #(.A1REG(0), .B1REG(0), .MREG(0), .PREG(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_tag(in_tag), .p_in(p_in), .carry_in(carry_in), .out_valid(ov0), .out_ready(out_ready),
    .out_p(op0), .out_carry(ocy0), .out_tag(otag0), .inflight(inf0), .ovf_err(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce, fl, iv;
    logic [3:0]  tag;
    logic [47:0] p;
    logic        cy, ordy;
    logic        e_ov;
    logic [47:0] e_p;
    logic [3:0]  e_tag;
    logic        e_cy, e_ir;
    logic [3:0]  e_inf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic c, input logic f, input logic v, input logic [3:0] t,
                              input logic [47:0] p, input logic cy, input logic r,
                              input logic eov, input logic [47:0] ep, input logic [3:0] et,
                              input logic ecy, input logic eir, input logic [3:0] einf);
    vec_t x;
    x.ce = c; x.fl = f; x.iv = v; x.tag = t; x.p = p; x.cy = cy; x.ordy = r;
    x.e_ov = eov; x.e_p = ep; x.e_tag = et; x.e_cy = ecy; x.e_ir = eir; x.e_inf = einf;
    return x;
  endfunction

  task automatic set_in(input logic c, input logic f, input logic v, input logic [3:0] t,
                        input logic [47:0] p, input logic cy, input logic r);
    ce = c; flush = f; in_valid = v; in_tag = t; p_in = p; carry_in = cy; out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input bit z, input bit chk_data, input logic e_ov,
                       input logic [47:0] e_p, input logic [3:0] e_tag, input logic e_cy,
                       input logic e_ir, input logic [3:0] e_inf);
    logic a_ov, a_cy, a_ir, a_ovf;
    logic [47:0] a_p;
    logic [3:0] a_tag, a_inf;
    if (z) begin
      a_ov = ov0; a_p = op0; a_tag = otag0; a_cy = ocy0; a_ir = ir0; a_inf = inf0; a_ovf = ovf0;
    end else begin
      a_ov = ov; a_p = op; a_tag = otag; a_cy = ocy; a_ir = ir; a_inf = inf; a_ovf = ovf;
    end
    n_vec++;
    if (a_ov !== e_ov || a_ir !== e_ir || a_inf !== e_inf || a_ovf !== 1'b0 ||
        (chk_data && (a_p !== e_p || a_tag !== e_tag || a_cy !== e_cy))) begin
      n_err++;
      $display("FAIL %s: got ov=%b p=%h tag=%h cy=%b ir=%b inf=%0d ovf=%b, want ov=%b p=%h tag=%h cy=%b ir=%b inf=%0d ovf=0",
               nm, a_ov, a_p, a_tag, a_cy, a_ir, a_inf, a_ovf, e_ov, e_p, e_tag, e_cy, e_ir, e_inf);
    end
  endtask

  initial begin
    //         ce    fl    iv    tag    p_in        cy    ordy | ov    p           tag    cy    ir    inflight
    // latency 3: issue tag 5, result appears three edges later
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h5, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h123, 1'b1, 1'b0, 1'b1, 48'h123, 4'h5, 1'b1, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b1, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd0));
    // two-cycle ce stall with the token in stage 1; in_valid during the stall is ignored
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h7, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 4'hE, 48'hAAA, 1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 48'hAAA, 1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h777, 1'b0, 1'b0, 1'b1, 48'h777, 4'h7, 1'b0, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b1, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd0));
    // back-to-back issue with out_ready low: credits run out after four issues
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h0, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h1, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd2));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h2, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd3));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h3, 48'h100, 1'b0, 1'b0, 1'b1, 48'h100, 4'h0, 1'b0, 1'b0, 4'd3));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h9, 48'h101, 1'b0, 1'b0, 1'b1, 48'h100, 4'h0, 1'b0, 1'b0, 4'd2));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h9, 48'h102, 1'b0, 1'b0, 1'b1, 48'h100, 4'h0, 1'b0, 1'b0, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h9, 48'h103, 1'b0, 1'b0, 1'b1, 48'h100, 4'h0, 1'b0, 1'b0, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'h9, 48'h0,   1'b0, 1'b1, 1'b1, 48'h101, 4'h1, 1'b0, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b1, 1'b1, 48'h102, 4'h2, 1'b0, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b1, 1'b1, 48'h103, 4'h3, 1'b0, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b1, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd0));
    // flush with two tokens in flight and one buffered result; issue/push that cycle are dropped
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'hA, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'hB, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd2));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 4'hC, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd3));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'hAAA, 1'b1, 1'b0, 1'b1, 48'hAAA, 4'hA, 1'b1, 1'b1, 4'd2));
    vt.push_back(mk(1'b1, 1'b1, 1'b1, 4'hD, 48'hBBB, 1'b0, 1'b0, 1'b1, 48'hAAA, 4'hA, 1'b1, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'hCCC, 1'b0, 1'b0, 1'b1, 48'hAAA, 4'hA, 1'b1, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'hDDD, 1'b0, 1'b0, 1'b1, 48'hAAA, 4'hA, 1'b1, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b1, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 48'h0,   1'b0, 1'b0, 1'b0, 48'h0,   4'h0, 1'b0, 1'b1, 4'd0));

    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 4'h0, 48'h0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_lat3", 1'b0, 1'b1, 1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 4'd0);
    check("reset_lat0", 1'b1, 1'b1, 1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 4'd0);

    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].ce, vt[i].fl, vt[i].iv, vt[i].tag, vt[i].p, vt[i].cy, vt[i].ordy);
      step();
      check($sformatf("vec%0d", i), 1'b0, vt[i].e_ov, vt[i].e_ov, vt[i].e_p, vt[i].e_tag,
            vt[i].e_cy, vt[i].e_ir, vt[i].e_inf);
    end

    // asynchronous reset with three results buffered and one token in flight
    for (int t = 1; t <= 4; t++) begin
      set_in(1'b1, 1'b0, 1'b1, 4'(t), 48'h0, 1'b0, 1'b0);
      step();
    end
    set_in(1'b1, 1'b0, 1'b0, 4'h0, 48'h0, 1'b0, 1'b0);
    step();
    step();
    check("rst_pre", 1'b0, 1'b1, 1'b1, 48'h0, 4'h1, 1'b0, 1'b0, 4'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", 1'b0, 1'b1, 1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 4'd0);
    #2;
    rst = 1'b0;
    step();
    check("rst_post", 1'b0, 1'b1, 1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 4'd0);
    step();
    step();
    step();
    check("rst_nopush", 1'b0, 1'b0, 1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 4'd0);

    // latency-0 instance: push on the issue edge with current p_in
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("lat0_reset", 1'b1, 1'b1, 1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 4'd0);
    set_in(1'b1, 1'b0, 1'b1, 4'h6, 48'hABC, 1'b1, 1'b0);
    step();
    check("lat0_push", 1'b1, 1'b1, 1'b1, 48'hABC, 4'h6, 1'b1, 1'b1, 4'd0);
    set_in(1'b1, 1'b1, 1'b1, 4'h7, 48'hDEF, 1'b0, 1'b1);
    step();
    check("lat0_flush", 1'b1, 1'b0, 1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
